// File: rtl/param_counter.sv
// Parametrised up/down counter with synchronous load, wrap-or-saturate ends,
// registered binary and Gray outputs, terminal-count flag and wrap pulse.
module param_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  assign w_at_max   = (r_count == MAX_COUNT);
  assign w_at_zero  = (r_count == '0);
  assign w_load_val = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  // Next value is chosen by comparing against the range ends, so the
  // increment/decrement never relies on WIDTH-bit overflow.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (load) begin
      w_next = w_load_val;
    end else if (en) begin
      if (up) begin
        if (!w_at_max) begin
          w_next = r_count + WIDTH'(1);
        end else if (!SATURATE) begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_next = r_count - WIDTH'(1);
        end else if (!SATURATE) begin
          w_next = MAX_COUNT;
          w_wrap = 1'b1;
        end
      end
    end
  end

  // Gray code is derived from the same next value so it never lags count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_gray  <= w_next ^ (w_next >> 1);
      r_wrap  <= w_wrap;
    end
  end

  assign count      = r_count;
  assign count_gray = r_gray;
  assign wrap       = r_wrap;
  assign tc         = (up && w_at_max) || (!up && w_at_zero);

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three instances (8-bit default, 4-bit mod-10 wrap,
// 4-bit mod-10 saturate) driven by directed steps and checked via a queue.
module tb_param_counter;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] cnt;
    logic [7:0] gray;
    logic       tc;
    logic       wrap;
  } exp_t;

  logic clk;
  logic [2:0] rst_v, en_v, up_v, load_v;
  logic [7:0] lv0;
  logic [3:0] lv1, lv2;
  logic [7:0] c0, g0;
  logic [3:0] c1, g1, c2, g2;
  logic [2:0] tc_v, wr_v;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  param_counter u_dut0 (
    .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
    .load_value(lv0), .count(c0), .count_gray(g0), .tc(tc_v[0]), .wrap(wr_v[0])
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
    .load_value(lv1), .count(c1), .count_gray(g1), .tc(tc_v[1]), .wrap(wr_v[1])
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
    .load_value(lv2), .count(c2), .count_gray(g2), .tc(tc_v[2]), .wrap(wr_v[2])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare
  task automatic check(input string name, input int inst,
                       input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] ac, ag;
      logic       at, aw;
      e = exp_q.pop_front();
      case (e.inst)
        2'd0:    begin ac = c0;         ag = g0;         at = tc_v[0]; aw = wr_v[0]; end
        2'd1:    begin ac = {4'd0, c1}; ag = {4'd0, g1}; at = tc_v[1]; aw = wr_v[1]; end
        default: begin ac = {4'd0, c2}; ag = {4'd0, g2}; at = tc_v[2]; aw = wr_v[2]; end
      endcase
      check("count", int'(e.inst), ac, e.cnt);
      check("count_gray", int'(e.inst), ag, e.gray);
      check("tc", int'(e.inst), {7'd0, at}, {7'd0, e.tc});
      check("wrap", int'(e.inst), {7'd0, aw}, {7'd0, e.wrap});
    end
  end

  // Driver: apply inputs to one instance (others idle), clock once, queue the
  // expected post-edge state, then return after the monitor has sampled.
  task automatic step(input int inst, input logic r, input logic e, input logic u,
                      input logic l, input logic [7:0] v,
                      input logic [7:0] exp_c, input logic exp_w);
    exp_t x;
    logic [7:0] mx;
    for (int i = 0; i < 3; i++) begin
      if (i != inst) begin
        en_v[i]   = 1'b0;
        load_v[i] = 1'b0;
      end
    end
    rst_v[inst]  = r;
    en_v[inst]   = e;
    up_v[inst]   = u;
    load_v[inst] = l;
    case (inst)
      0:       lv0 = v;
      1:       lv1 = v[3:0];
      default: lv2 = v[3:0];
    endcase
    mx = (inst == 0) ? 8'd255 : 8'd9;
    @(posedge clk);
    #1;
    x.inst = 2'(inst);
    x.cnt  = exp_c;
    x.gray = exp_c ^ (exp_c >> 1);
    x.tc   = u ? (exp_c == mx) : (exp_c == 8'd0);
    x.wrap = exp_w;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Hand-computed sequences for the mod-10 wrapping instance
  logic [7:0] up_tab [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
  logic [7:0] dn_tab [12] = '{8'd1, 8'd0, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  logic [7:0] sat_up [4]  = '{8'd8, 8'd9, 8'd9, 8'd9};
  logic [7:0] sat_dn [4]  = '{8'd1, 8'd0, 8'd0, 8'd0};
  logic [7:0] tog_c  [8]  = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
  logic       tog_e  [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_v = 3'b111; en_v = '0; up_v = '0; load_v = '0;
    lv0 = '0; lv1 = '0; lv2 = '0;
    @(negedge clk);
    #1;

    // 8-bit default: reset, 260 up steps, then down through zero
    step(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd77, 8'd0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 260; k++)
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'(k % 256), (k % 256) == 0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd255, 1'b0);

    // Mod-10 wrap: up 12 steps, then down 12 steps
    step(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 12; k++)
      step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, up_tab[k], k == 9);
    for (int k = 0; k < 12; k++)
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, dn_tab[k], k == 2);

    // Out-of-range load clamps and suppresses wrap; next step wraps
    step(1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd15, 8'd9, 1'b0);
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);

    // Enable toggling, then reset with load and en asserted
    for (int k = 0; k < 8; k++)
      step(1, 1'b0, tog_e[k], 1'b1, 1'b0, 8'd0, tog_c[k], 1'b0);
    step(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd7, 8'd0, 1'b0);
    step(1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd9, 8'd9, 1'b0);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0);

    // Mod-10 saturate: load 7 and count up into the ceiling, then down to floor
    step(2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    step(2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 8'd7, 1'b0);
    for (int k = 0; k < 4; k++)
      step(2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, sat_up[k], 1'b0);
    step(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0);
    for (int k = 0; k < 4; k++)
      step(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, sat_dn[k], 1'b0);
    step(2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd12, 8'd9, 1'b0);
    step(2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0);

    // Final report
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
